multi_cycle_ctrl: RTL and testbench
===================================

// Module: multi_cycle_ctrl
// PURPOSE
//  Moore-FSM controller that sequences the shared-memory, multi-cycle MIPS datapath.
//  Each instruction is split into FETCH/DECODE/EXEC/MEM/WB steps, so one ALU and one memory port are reused.
//  Sits beside the datapath in cpu/. Drives mux selects, write enables and ALU control.
//  Stalls on a memory ready handshake. Counts retired instructions.
// PARAMETERS
//  CNT_W  32  width of retired-instruction counter (wraps modulo 2**CNT_W)
// PORTS
//  clk           in   1      single clock, rising edge
//  reset         in   1      asynchronous, active-high reset
//  op            in   6      opcode from instruction register
//  funct         in   6      funct field from instruction register
//  zero          in   1      ALU zero flag
//  mem_ready     in   1      memory completes current access this cycle
//  iord          out  1      0: address=PC, 1: address=ALUOut
//  mem_write     out  1      memory write strobe
//  ir_write      out  1      load instruction register
//  reg_dst       out  1      0: rt, 1: rd
//  mem_to_reg    out  1      0: ALUOut, 1: Data reg
//  reg_write     out  1      register file write enable
//  alu_src_a     out  1      0: PC, 1: A
//  alu_src_b     out  2      00: B, 01: 4, 10: SignImm, 11: SignImm<<2
//  pc_src        out  2      00: ALUResult, 01: ALUOut, 10: jump target
//  pc_en         out  1      PC register load enable
//  alu_ctrl_sig  out  3      010 add, 110 sub, 000 and, 001 or, 111 slt
//  illegal       out  1      one-cycle pulse: unsupported op/funct decoded
//  retired       out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - Reset values:
//    - state=FETCH; retired=0; illegal=0.
//    - All enables (mem_write, ir_write, reg_write, pc_en) are 0 while reset is high.
//    - Mux outputs take their FETCH values.
//  - Outputs are decoded from state only (Moore), except these gated terms:
//    - pc_en = pc_write | (branch & zero).
//    - ir_write and FETCH pc_write are ANDed with mem_ready.
//  - Per-state outputs (unlisted signals = 0):
//    - FETCH:  iord=0, src_b=01, alu_op=00, ir_write=pc_write=mem_ready. Stay until mem_ready=1, then ->DECODE.
//    - DECODE: src_b=11, alu_op=00. Next state by op:
//      - 100011 lw / 101011 sw -> MEMADR
//      - 000000 -> EXEC
//      - 000100 -> BRANCH
//      - 001000 -> ADDIEX
//      - 000010 -> JUMP
//      - other  -> FETCH with illegal=1
//    - MEMADR: src_a=1, src_b=10, alu_op=00. lw->MEMRD, sw->MEMWR.
//    - MEMRD:  iord=1. Hold until mem_ready, then ->MEMWB.
//    - MEMWB:  reg_dst=0, mem_to_reg=1, reg_write=1; ->FETCH.
//    - MEMWR:  iord=1, mem_write=1. Hold until mem_ready, then ->FETCH.
//    - EXEC:   src_a=1, src_b=00, alu_op=10. Valid funct ->ALUWB. Unsupported funct ->FETCH with illegal=1.
//    - ALUWB:  reg_dst=1, mem_to_reg=0, reg_write=1; ->FETCH.
//    - BRANCH: src_a=1, src_b=00, alu_op=01, pc_src=01, branch=1; ->FETCH.
//    - ADDIEX: src_a=1, src_b=10, alu_op=00; ->ADDIWB.
//    - ADDIWB: reg_dst=0, reg_write=1; ->FETCH.
//    - JUMP:   pc_src=10, pc_write=1; ->FETCH.
//  - ALU control:
//    - alu_op=00 -> 010; alu_op=01 -> 110.
//    - alu_op=10 decodes funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, else 010.
//  - Latencies with mem_ready tied high:
//    - lw=5, sw=4, R=4, addi=4, beq=3, j=3 cycles.
//    - Each cycle mem_ready=0 in FETCH/MEMRD/MEMWR adds one cycle.
//  - Retired counter:
//    - retired+=1 on exit to FETCH from MEMWB, MEMWR (with mem_ready), ALUWB, BRANCH, ADDIWB, JUMP.
//    - Illegal exits do not count. Counter wraps at 2**CNT_W-1 -> 0.
//  - Reset mid-instruction: the state returns to FETCH immediately (async). No partial write enable is emitted after reset asserts.
//  - op/funct must be stable from DECODE until the instruction ends (the IR is only written in FETCH).
// CONFIGURATION
//  MULTI_CYCLE_CTRL_BNE_EN
//    - Defined: op 000101 (bne) -> BRANCH state with pc_en = pc_write | (branch & ~zero); latency 3; counts as retired.
//    - Undefined: op 000101 is illegal (->FETCH, illegal pulse, not counted).
// TESTING
//  1. Assert reset mid-MEMRD, release -> state=FETCH, all enables 0, retired=0, next mem_ready fetch sets ir_write=1.
//  2. lw (op 100011), mem_ready=1 -> 5 cycles FETCH,DECODE,MEMADR,MEMRD,MEMWB; reg_write=1 and mem_to_reg=1 in cycle 5; retired=1.
//  3. R-type funct 101010, then funct 000111 -> alu_ctrl_sig=111 in EXEC then ALUWB reg_dst=1; second gives illegal pulse, retired unchanged.
//  4. beq with zero=1, then zero=0 -> pc_en=1 and pc_src=01 in BRANCH only for the first.
//  5. sw with mem_ready low for 3 cycles in MEMWR -> mem_write held 4 cycles; ->FETCH after mem_ready; total latency 7.
//  6. op 000101 with zero=0 -> BNE_EN: pc_en=1 in BRANCH; without macro: illegal=1 after DECODE, no BRANCH.

Source files
------------

// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and its MIPS datapath.
// master = controller side, slave = datapath side.
interface multi_cycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             iord;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_src;
    logic             pc_en;
    logic [2:0]       alu_ctrl_sig;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  op, funct, zero, mem_ready,
        output iord, mem_write, ir_write, reg_dst, mem_to_reg,
        output reg_write, alu_src_a, alu_src_b, pc_src, pc_en,
        output alu_ctrl_sig, illegal, retired
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  iord, mem_write, ir_write, reg_dst, mem_to_reg,
        input  reg_write, alu_src_a, alu_src_b, pc_src, pc_en,
        input  alu_ctrl_sig, illegal, retired
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Moore FSM sequencing the shared-memory multi-cycle MIPS datapath.
// Optional macro MULTI_CYCLE_CTRL_BNE_EN routes bne through BRANCH.
module multi_cycle_ctrl #(
    parameter int CNT_W = 32
) (
    input logic                clk,
    input logic                reset,
    multi_cycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTI_CYCLE_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    state_t state, state_next;

    logic is_lw, is_sw, is_rtype, is_beq, is_bne, is_addi, is_j;
    logic op_ok, funct_ok;

    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg;
    logic       reg_write, alu_src_a, pc_write, branch, branch_take;
    logic [1:0] alu_src_b, pc_src, alu_op;
    logic [2:0] alu_ctrl;

    logic             retire, illegal_set;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;

    // classify the opcode held in the instruction register
    always_comb begin
        is_lw    = (bus.op == OP_LW);
        is_sw    = (bus.op == OP_SW);
        is_rtype = (bus.op == OP_RTYPE);
        is_beq   = (bus.op == OP_BEQ);
        is_addi  = (bus.op == OP_ADDI);
        is_j     = (bus.op == OP_J);
`ifdef MULTI_CYCLE_CTRL_BNE_EN
        is_bne   = (bus.op == OP_BNE);
`else
        is_bne   = 1'b0;
`endif
        op_ok = is_lw | is_sw | is_rtype | is_beq
              | is_bne | is_addi | is_j;
    end

    // R-type functions the ALU supports
    always_comb begin
        funct_ok = (bus.funct == FN_ADD) | (bus.funct == FN_SUB)
                 | (bus.funct == FN_AND) | (bus.funct == FN_OR)
                 | (bus.funct == FN_SLT);
    end

    // state register, reset returns straight to FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // next-state sequencing
    always_comb begin
        state_next = state;
        unique case (state)
            FETCH: begin
                if (bus.mem_ready) state_next = DECODE;
            end
            DECODE: begin
                unique case (1'b1)
                    is_lw, is_sw:   state_next = MEMADR;
                    is_rtype:       state_next = EXEC;
                    is_beq, is_bne: state_next = BRANCH;
                    is_addi:        state_next = ADDIEX;
                    is_j:           state_next = JUMP;
                    default:        state_next = FETCH;
                endcase
            end
            MEMADR: state_next = is_sw ? MEMWR : MEMRD;
            MEMRD: begin
                if (bus.mem_ready) state_next = MEMWB;
            end
            MEMWB: state_next = FETCH;
            MEMWR: begin
                if (bus.mem_ready) state_next = FETCH;
            end
            EXEC:   state_next = funct_ok ? ALUWB : FETCH;
            ALUWB:  state_next = FETCH;
            BRANCH: state_next = FETCH;
            ADDIEX: state_next = ADDIWB;
            ADDIWB: state_next = FETCH;
            JUMP:   state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // Moore output decode; only FETCH strobes look at mem_ready
    always_comb begin
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_op     = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        unique case (state)
            FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
            end
            DECODE: begin
                alu_src_b = 2'b11;
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                iord = 1'b1;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ADDIWB: begin
                reg_write = 1'b1;
            end
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: begin
                alu_src_b = 2'b01;
            end
        endcase
    end

    // ALU operation select
    always_comb begin
        alu_ctrl = 3'b010;
        unique case (alu_op)
            2'b00: alu_ctrl = 3'b010;
            2'b01: alu_ctrl = 3'b110;
            2'b10: begin
                unique case (bus.funct)
                    FN_ADD:  alu_ctrl = 3'b010;
                    FN_SUB:  alu_ctrl = 3'b110;
                    FN_AND:  alu_ctrl = 3'b000;
                    FN_OR:   alu_ctrl = 3'b001;
                    FN_SLT:  alu_ctrl = 3'b111;
                    default: alu_ctrl = 3'b010;
                endcase
            end
            default: alu_ctrl = 3'b010;
        endcase
    end

    // branch condition: bne inverts the zero test
    always_comb begin
        if (is_bne) begin
            branch_take = branch & ~bus.zero;
        end else begin
            branch_take = branch & bus.zero;
        end
    end

    // retirement and illegal-decode detection
    always_comb begin
        retire = (state_next == FETCH)
               & (state inside {MEMWB, MEMWR, ALUWB,
                                BRANCH, ADDIWB, JUMP});
        illegal_set = ((state == DECODE) & ~op_ok)
                    | ((state == EXEC) & ~funct_ok);
    end

    // retired counter and one-cycle illegal pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (retire) retired_q <= retired_q + CNT_W'(1);
            illegal_q <= illegal_set;
        end
    end

    // drive the bundle; enables are held low while reset is high
    assign bus.iord         = iord;
    assign bus.mem_write    = mem_write & ~reset;
    assign bus.ir_write     = ir_write & ~reset;
    assign bus.reg_dst      = reg_dst;
    assign bus.mem_to_reg   = mem_to_reg;
    assign bus.reg_write    = reg_write & ~reset;
    assign bus.alu_src_a    = alu_src_a;
    assign bus.alu_src_b    = alu_src_b;
    assign bus.pc_src       = pc_src;
    assign bus.pc_en        = (pc_write | branch_take) & ~reset;
    assign bus.alu_ctrl_sig = alu_ctrl;
    assign bus.illegal      = illegal_q;
    assign bus.retired      = retired_q;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: directed instruction sequences.
// Honours MULTI_CYCLE_CTRL_BNE_EN the same way as the design.
module tb_multi_cycle_ctrl;
    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic       pc_en;
        logic [2:0] alu;
        logic       ill;
    } out_t;

    typedef struct {
        string       nm;
        out_t        e;
        logic [31:0] ret;
    } rec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    multi_cycle_ctrl_if #(.CNT_W(32)) bus ();

    multi_cycle_ctrl #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    rec_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_ret = 0;
    bit          pend_ill = 1'b0;

    function automatic out_t o(
        input logic iord, input logic mw, input logic irw,
        input logic rdst, input logic m2r, input logic rw,
        input logic sa, input logic [1:0] sb, input logic [1:0] ps,
        input logic pcen, input logic [2:0] alu, input logic ill);
        out_t r;
        r.iord = iord; r.mem_write = mw; r.ir_write = irw;
        r.reg_dst = rdst; r.mem_to_reg = m2r; r.reg_write = rw;
        r.src_a = sa; r.src_b = sb; r.pc_src = ps;
        r.pc_en = pcen; r.alu = alu; r.ill = ill;
        return r;
    endfunction

    function automatic out_t sample();
        out_t r;
        r.iord = bus.iord; r.mem_write = bus.mem_write;
        r.ir_write = bus.ir_write; r.reg_dst = bus.reg_dst;
        r.mem_to_reg = bus.mem_to_reg; r.reg_write = bus.reg_write;
        r.src_a = bus.alu_src_a; r.src_b = bus.alu_src_b;
        r.pc_src = bus.pc_src; r.pc_en = bus.pc_en;
        r.alu = bus.alu_ctrl_sig; r.ill = bus.illegal;
        return r;
    endfunction

    // hand-derived per-state output vectors
    out_t R, FR, FRI, DEC, MA, MR, MWB, MW, AWB, AIW, J;
    initial begin
        R   = o(0,0,0,0,0,0,0,2'b01,2'b00,0,3'b010,0);
        FR  = o(0,0,1,0,0,0,0,2'b01,2'b00,1,3'b010,0);
        FRI = o(0,0,1,0,0,0,0,2'b01,2'b00,1,3'b010,1);
        DEC = o(0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,0);
        MA  = o(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0);
        MR  = o(1,0,0,0,0,0,0,2'b00,2'b00,0,3'b010,0);
        MWB = o(0,0,0,0,1,1,0,2'b00,2'b00,0,3'b010,0);
        MW  = o(1,1,0,0,0,0,0,2'b00,2'b00,0,3'b010,0);
        AWB = o(0,0,0,1,0,1,0,2'b00,2'b00,0,3'b010,0);
        AIW = o(0,0,0,0,0,1,0,2'b00,2'b00,0,3'b010,0);
        J   = o(0,0,0,0,0,0,0,2'b00,2'b10,1,3'b010,0);
    end

    function automatic out_t ex(input logic [2:0] alu);
        return o(0,0,0,0,0,0,1,2'b00,2'b00,0,alu,0);
    endfunction

    function automatic out_t br(input logic take);
        return o(0,0,0,0,0,0,1,2'b00,2'b01,take,3'b110,0);
    endfunction

    // monitor: the DUT presents a Moore output vector every cycle
    always @(negedge clk) begin
        rec_t r;
        out_t a;
        if (q.size() > 0) begin
            r = q.pop_front();
            a = sample();
            checks++;
            if (a !== r.e) begin
                errors++;
                $display("FAIL %s outputs: got %b want %b",
                         r.nm, a, r.e);
            end
            checks++;
            if (bus.retired !== r.ret) begin
                errors++;
                $display("FAIL %s retired: got %0d want %0d",
                         r.nm, bus.retired, r.ret);
            end
        end
    end

    task automatic step(input string nm, input logic mr,
                        input out_t e);
        rec_t r;
        bus.mem_ready = mr;
        r.nm = nm;
        r.e = e;
        r.ret = exp_ret;
        q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string nm);
        step(nm, 1'b1, pend_ill ? FRI : FR);
        pend_ill = 1'b0;
    endtask

    initial begin
        bus.op = 6'b000000;
        bus.funct = 6'b100000;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        step("rst0", 1'b1, R);
        step("rst1", 1'b1, R);

        // lw cut short by reset in MEMRD
        reset = 1'b0;
        bus.op = 6'b100011;
        fetch("t1_f");
        step("t1_d", 1'b1, DEC);
        step("t1_ma", 1'b1, MA);
        reset = 1'b1;
        exp_ret = 0;
        step("t1_rst_mrd", 1'b0, R);
        step("t1_rst_hold", 1'b1, R);
        reset = 1'b0;

        // lw with one fetch wait and one read wait
        step("t2_fwait", 1'b0, R);
        fetch("t2_f");
        step("t2_d", 1'b1, DEC);
        step("t2_ma", 1'b1, MA);
        step("t2_mrwait", 1'b0, MR);
        step("t2_mr", 1'b1, MR);
        step("t2_wb", 1'b1, MWB);
        exp_ret++;

        // R-type slt, sub, then unsupported funct
        bus.op = 6'b000000;
        bus.funct = 6'b101010;
        fetch("t3_slt_f");
        step("t3_slt_d", 1'b1, DEC);
        step("t3_slt_ex", 1'b1, ex(3'b111));
        step("t3_slt_wb", 1'b1, AWB);
        exp_ret++;
        bus.funct = 6'b100010;
        fetch("t3_sub_f");
        step("t3_sub_d", 1'b1, DEC);
        step("t3_sub_ex", 1'b1, ex(3'b110));
        step("t3_sub_wb", 1'b1, AWB);
        exp_ret++;
        bus.funct = 6'b000111;
        fetch("t3_bad_f");
        step("t3_bad_d", 1'b1, DEC);
        step("t3_bad_ex", 1'b1, ex(3'b010));
        pend_ill = 1'b1;

        // beq taken then not taken
        bus.op = 6'b000100;
        bus.zero = 1'b1;
        fetch("t4_beq1_f");
        step("t4_beq1_d", 1'b1, DEC);
        step("t4_beq1_br", 1'b1, br(1'b1));
        exp_ret++;
        bus.zero = 1'b0;
        fetch("t4_beq0_f");
        step("t4_beq0_d", 1'b1, DEC);
        step("t4_beq0_br", 1'b1, br(1'b0));
        exp_ret++;

        // sw with three wait cycles in MEMWR
        bus.op = 6'b101011;
        fetch("t5_f");
        step("t5_d", 1'b1, DEC);
        step("t5_ma", 1'b1, MA);
        step("t5_mw0", 1'b0, MW);
        step("t5_mw1", 1'b0, MW);
        step("t5_mw2", 1'b0, MW);
        step("t5_mw3", 1'b1, MW);
        exp_ret++;

        // addi and j
        bus.op = 6'b001000;
        fetch("addi_f");
        step("addi_d", 1'b1, DEC);
        step("addi_ex", 1'b1, MA);
        step("addi_wb", 1'b1, AIW);
        exp_ret++;
        bus.op = 6'b000010;
        fetch("j_f");
        step("j_d", 1'b1, DEC);
        step("j_j", 1'b1, J);
        exp_ret++;

        // bne with zero=0
        bus.op = 6'b000101;
        bus.zero = 1'b0;
        fetch("t6_f");
        step("t6_d", 1'b1, DEC);
`ifdef MULTI_CYCLE_CTRL_BNE_EN
        step("t6_br", 1'b1, br(1'b1));
        exp_ret++;
`else
        pend_ill = 1'b1;
`endif

        // unknown opcode
        bus.op = 6'b111111;
        fetch("bad_op_f");
        step("bad_op_d", 1'b1, DEC);
        pend_ill = 1'b1;
        bus.op = 6'b000000;
        bus.funct = 6'b100000;
        fetch("end_f");

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
